// File: rtl/cache_ctrl_pkg.sv
// Shared geometry, types, state encoding and small helpers for the
// direct-mapped write-through cache controller.
package cache_ctrl_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int ENTRY_WIDTH  = 10;
    localparam int OFFSET_WIDTH = 2;
    localparam int TAG_WIDTH    = ADDR_WIDTH - ENTRY_WIDTH - OFFSET_WIDTH;

    localparam int CACHE_1K = 1 << ENTRY_WIDTH;   // number of lines
    localparam int WORD_4B  = 1 << OFFSET_WIDTH;  // bytes per word

    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [DATA_WIDTH-1:0]  word_t;
    typedef logic [ENTRY_WIDTH-1:0] index_t;
    typedef logic [TAG_WIDTH-1:0]   tag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_RD,
        ST_FILL,
        ST_MEM_WR,
        ST_UPD,
        ST_RESP
    } state_e;

    function automatic index_t addr_index(input addr_t a);
        return a[OFFSET_WIDTH +: ENTRY_WIDTH];
    endfunction

    function automatic tag_t addr_tag(input addr_t a);
        return a[ADDR_WIDTH-1 -: TAG_WIDTH];
    endfunction

    // Word-aligned form of a byte address: the offset bits are cleared.
    function automatic addr_t word_addr(input addr_t a);
        return a & ~addr_t'(WORD_4B - 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Bundle of the core, next-level memory and data-array buses around the
// cache controller. The controller takes the slave view; the core, memory
// and data array together form the master side.
interface cache_ctrl_if;
    import cache_ctrl_pkg::*;

    // Core request bus
    logic   cpu_req;
    logic   cpu_we;
    addr_t  cpu_addr;
    word_t  cpu_wdata;
    logic   cpu_ready;
    logic   cpu_valid;
    word_t  cpu_rdata;

    // Next-level memory bus
    logic   mem_req;
    logic   mem_we;
    addr_t  mem_addr;
    word_t  mem_wdata;
    logic   mem_ack;
    word_t  mem_rdata;

    // cache_block data array
    index_t cb_index;
    logic   cb_we;
    word_t  cb_din;
    word_t  cb_dout;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_valid, cpu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  cb_index, cb_we, cb_din,
        output cb_dout
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_valid, cpu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output cb_index, cb_we, cb_din,
        input  cb_dout
    );

endinterface

// File: rtl/cache_ctrl_tag_array.sv
// Tag and valid storage for the 1K lines: combinational read, synchronous
// write, and a single-cycle synchronous clear of every valid bit.
module cache_tag_array
    import cache_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  index_t rd_index_i,
    output tag_t   rd_tag_o,
    output logic   rd_valid_o,
    input  logic   wr_en_i,
    input  index_t wr_index_i,
    input  tag_t   wr_tag_i
);

    tag_t                tag_q [CACHE_1K];
    logic [CACHE_1K-1:0] valid_q;

    // Tag write on fill.
    // NOTE: the tag RAM is deliberately left out of reset; the valid bits
    // alone decide whether a stored tag means anything.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    // Valid bits: whole-array clear on reset, set on fill.
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_valid_o = valid_q[rd_index_i];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through (no write-allocate) cache controller driving
// the cache_block data array and the next-level memory.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    cache_ctrl_if.slave bus,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    state_e      state_q, state_d;
    addr_t       addr_q;
    logic        we_q;
    word_t       wdata_q;
    word_t       rdata_q;
    logic        hit_q;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    index_t      req_index;
    tag_t        req_tag;
    tag_t        stored_tag;
    logic        stored_valid;
    logic        lookup_hit;
    logic        tag_wr_en;

    assign req_index  = addr_index(addr_q);
    assign req_tag    = addr_tag(addr_q);
    assign lookup_hit = stored_valid && (stored_tag == req_tag);

    cache_tag_array u_tags (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (req_index),
        .rd_tag_o   (stored_tag),
        .rd_valid_o (stored_valid),
        .wr_en_i    (tag_wr_en),
        .wr_index_i (req_index),
        .wr_tag_i   (req_tag)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, read-data latching, lookup result and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == ST_IDLE && bus.cpu_req) begin
                addr_q  <= bus.cpu_addr;
                we_q    <= bus.cpu_we;
                wdata_q <= bus.cpu_wdata;
                rdata_q <= '0;           // writes respond with zero data
            end
            if (state_q == ST_LOOKUP) begin
                hit_q <= lookup_hit;
                if (lookup_hit) begin
                    hit_cnt_q <= sat_inc(hit_cnt_q);
                    if (!we_q) begin
                        rdata_q <= bus.cb_dout;
                    end
                end else begin
                    miss_cnt_q <= sat_inc(miss_cnt_q);
                end
            end
            if (state_q == ST_MEM_RD && bus.mem_ack) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Next state and all bus outputs, decoded from the current state.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        bus.cpu_ready = 1'b0;
        bus.cpu_valid = 1'b0;
        bus.cpu_rdata = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.cb_index  = '0;
        bus.cb_we     = 1'b0;
        bus.cb_din    = '0;
        tag_wr_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.cpu_ready = 1'b1;
                if (bus.cpu_req) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                bus.cb_index = req_index;
                if (we_q)            state_d = ST_MEM_WR;
                else if (lookup_hit) state_d = ST_RESP;
                else                 state_d = ST_MEM_RD;
            end
            ST_MEM_RD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = word_addr(addr_q);
                if (bus.mem_ack) state_d = ST_FILL;
            end
            ST_FILL: begin
                bus.cb_we    = 1'b1;
                bus.cb_index = req_index;
                bus.cb_din   = rdata_q;
                tag_wr_en    = 1'b1;
                state_d      = ST_RESP;
            end
            ST_MEM_WR: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = word_addr(addr_q);
                bus.mem_wdata = wdata_q;
                if (bus.mem_ack) state_d = hit_q ? ST_UPD : ST_RESP;
            end
            ST_UPD: begin
                bus.cb_we    = 1'b1;
                bus.cb_index = req_index;
                bus.cb_din   = wdata_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                bus.cpu_valid = 1'b1;
                bus.cpu_rdata = rdata_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl: the bench plays the core,
// the next-level memory and the cache_block data array.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    cache_ctrl_if bus ();

    cache_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cache_block model: 1K x 32, synchronous write, combinational read
    word_t cb_mem [CACHE_1K];
    always @(posedge clk) begin
        if (bus.cb_we) cb_mem[bus.cb_index] <= bus.cb_din;
    end
    assign bus.cb_dout = cb_mem[bus.cb_index];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observations from the last transaction
    int     r_lat;
    word_t  r_rdata;
    logic   r_mem_seen;
    logic   r_mem_we;
    addr_t  r_mem_addr;
    word_t  r_mem_wdata;
    logic   r_mem_unstable;
    int     r_cb_pulses;
    index_t r_cb_idx;
    word_t  r_cb_din;

    // One core request; the memory side acks after mem_lat cycles of mem_req.
    task automatic do_req(input logic we, input addr_t addr, input word_t wdata,
                          input int mem_lat, input word_t mem_data);
        int wait_cnt;
        r_lat = -1; r_rdata = '0; r_mem_seen = 1'b0; r_mem_we = 1'b0;
        r_mem_addr = '0; r_mem_wdata = '0; r_mem_unstable = 1'b0;
        r_cb_pulses = 0; r_cb_idx = '0; r_cb_din = '0;
        wait_cnt = 0;
        @(negedge clk);
        check("ready_before_req", bus.cpu_ready, 1);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bus.cpu_req = 1'b0;
            bus.mem_ack = 1'b0;
            if (bus.cb_we) begin
                r_cb_pulses++;
                r_cb_idx = bus.cb_index;
                r_cb_din = bus.cb_din;
            end
            if (bus.mem_req) begin
                if (!r_mem_seen) begin
                    r_mem_seen  = 1'b1;
                    r_mem_we    = bus.mem_we;
                    r_mem_addr  = bus.mem_addr;
                    r_mem_wdata = bus.mem_wdata;
                end else if (bus.mem_we != r_mem_we || bus.mem_addr != r_mem_addr ||
                             bus.mem_wdata != r_mem_wdata) begin
                    r_mem_unstable = 1'b1;
                end
                wait_cnt++;
                if (wait_cnt == mem_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_data;
                end
            end
            if (bus.cpu_valid) begin
                r_lat   = k;
                r_rdata = bus.cpu_rdata;
                break;
            end
        end
        check("cpu_valid_seen", (r_lat > 0), 1);
        check("mem_stable", r_mem_unstable, 0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("valid_single_cycle", bus.cpu_valid, 0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", bus.cpu_ready, 1);
        check("rst_cpu_valid", bus.cpu_valid, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_cb_we", bus.cb_we, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;

        // Cold read miss, memory answers after 3 cycles
        do_req(1'b0, 32'h0000_0008, '0, 3, 32'hDEAD_BEEF);
        check("cold_mem_seen", r_mem_seen, 1);
        check("cold_mem_we", r_mem_we, 0);
        check("cold_mem_addr", r_mem_addr, 32'h8);
        check("cold_cb_pulses", r_cb_pulses, 1);
        check("cold_cb_idx", r_cb_idx, 2);
        check("cold_cb_din", r_cb_din, 32'hDEAD_BEEF);
        check("cold_rdata", r_rdata, 32'hDEAD_BEEF);
        check("cold_lat", r_lat, 6);
        check("cold_miss_cnt", miss_cnt, 1);
        check("cold_hit_cnt", hit_cnt, 0);

        // Repeat read hits
        do_req(1'b0, 32'h0000_0008, '0, 1, 32'h0);
        check("hit_mem_seen", r_mem_seen, 0);
        check("hit_lat", r_lat, 2);
        check("hit_rdata", r_rdata, 32'hDEAD_BEEF);
        check("hit_cb_pulses", r_cb_pulses, 0);
        check("hit_hit_cnt", hit_cnt, 1);

        // Write hit: memory write then data-array update
        do_req(1'b1, 32'h0000_0008, 32'h0FF0, 1, 32'h0);
        check("wrhit_mem_we", r_mem_we, 1);
        check("wrhit_mem_addr", r_mem_addr, 32'h8);
        check("wrhit_mem_wdata", r_mem_wdata, 32'h0FF0);
        check("wrhit_cb_pulses", r_cb_pulses, 1);
        check("wrhit_cb_idx", r_cb_idx, 2);
        check("wrhit_cb_din", r_cb_din, 32'h0FF0);
        check("wrhit_rdata", r_rdata, 0);
        check("wrhit_lat", r_lat, 4);
        check("wrhit_hit_cnt", hit_cnt, 2);

        do_req(1'b0, 32'h0000_0008, '0, 1, 32'h0);
        check("rdafter_mem_seen", r_mem_seen, 0);
        check("rdafter_rdata", r_rdata, 32'h0FF0);
        check("rdafter_hit_cnt", hit_cnt, 3);

        // Write miss at index 6: memory only, no allocate
        do_req(1'b1, 32'h0000_0018, 32'h1234_5678, 2, 32'h0);
        check("wrmiss_mem_we", r_mem_we, 1);
        check("wrmiss_mem_addr", r_mem_addr, 32'h18);
        check("wrmiss_mem_wdata", r_mem_wdata, 32'h1234_5678);
        check("wrmiss_cb_pulses", r_cb_pulses, 0);
        check("wrmiss_lat", r_lat, 4);
        check("wrmiss_miss_cnt", miss_cnt, 2);

        do_req(1'b0, 32'h0000_0018, '0, 1, 32'h1234_5678);
        check("rd18_mem_seen", r_mem_seen, 1);
        check("rd18_mem_addr", r_mem_addr, 32'h18);
        check("rd18_cb_idx", r_cb_idx, 6);
        check("rd18_rdata", r_rdata, 32'h1234_5678);
        check("rd18_miss_cnt", miss_cnt, 3);

        // Conflict at index 2 with a new tag
        do_req(1'b0, 32'h0000_1008, '0, 2, 32'hCAFE_F00D);
        check("conf_mem_addr", r_mem_addr, 32'h1008);
        check("conf_cb_idx", r_cb_idx, 2);
        check("conf_rdata", r_rdata, 32'hCAFE_F00D);
        check("conf_miss_cnt", miss_cnt, 4);

        do_req(1'b0, 32'h0000_0008, '0, 1, 32'h0FF0);
        check("evict_mem_seen", r_mem_seen, 1);
        check("evict_rdata", r_rdata, 32'h0FF0);
        check("evict_miss_cnt", miss_cnt, 5);

        // Offset bits ignored: byte 3 of the same word hits and memory sees no request
        do_req(1'b0, 32'h0000_000B, '0, 1, 32'h0);
        check("offs_mem_seen", r_mem_seen, 0);
        check("offs_rdata", r_rdata, 32'h0FF0);
        check("offs_lat", r_lat, 2);
        check("offs_hit_cnt", hit_cnt, 4);

        // Reset during MEM_RD, then a late mem_ack
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h2000_0008;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.cpu_req = 1'b0;
            if (bus.mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("rstmid_mem_req_seen", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_mem_req_drop", bus.mem_req, 0);
        check("rstmid_ready", bus.cpu_ready, 1);
        check("rstmid_miss_cnt", miss_cnt, 0);
        check("rstmid_hit_cnt", hit_cnt, 0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.cpu_valid || bus.cb_we || bus.mem_req) seen = 1'b1;
        end
        check("rstmid_no_activity", seen, 0);
        check("rstmid_idle", bus.cpu_ready, 1);

        // Valid bits cleared: former hit now misses
        do_req(1'b0, 32'h0000_0008, '0, 1, 32'h0FF0);
        check("postrst_mem_seen", r_mem_seen, 1);
        check("postrst_mem_addr", r_mem_addr, 32'h8);
        check("postrst_rdata", r_rdata, 32'h0FF0);
        check("postrst_miss_cnt", miss_cnt, 1);
        check("postrst_hit_cnt", hit_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Direct-mapped, write-through cache controller that sits directly upstream of cache_block, the 1K x 32-bit data array. It accepts word requests from the core, splits the address into tag, index and offset, and holds the tag and valid arrays internally. On a read miss it fetches the word from next-level memory and fills cache_block. It is the only driver of cache_block's index, we and din, and the only consumer of its dout.

Parameters:
ADDR_WIDTH, 32, byte address width of core requests
DATA_WIDTH, 32, word width; matches cache_block
ENTRY_WIDTH, 10, index width (1K entries)
OFFSET_WIDTH, 2, byte offset within a word
TAG_WIDTH, ADDR_WIDTH-ENTRY_WIDTH-OFFSET_WIDTH (20), derived local parameter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  core request strobe
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  byte address
cpu_wdata  in  DATA_WIDTH  write data
cpu_ready  out  1  controller idle; request accepted when cpu_req & cpu_ready
cpu_valid  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_valid
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_WIDTH  word-aligned address (low OFFSET_WIDTH bits = 0)
mem_wdata  out  DATA_WIDTH  memory write data
mem_ack  in  1  memory done; mem_rdata valid same cycle for reads
mem_rdata  in  DATA_WIDTH  memory read data
cb_index  out  ENTRY_WIDTH  to cache_block index
cb_we  out  1  to cache_block we
cb_din  out  DATA_WIDTH  to cache_block din
cb_dout  in  DATA_WIDTH  from cache_block dout (combinational read)
hit_cnt  out  32  saturating hit counter
miss_cnt  out  32  saturating miss counter

Behaviour:
- Clocking: single clock domain, clk. rst is synchronous and active-high.
- Reset values: all outputs 0 except cpu_ready=1. State goes to IDLE. All 1K valid bits clear in one cycle. Counters clear. The tag array has no reset.
- Request handling: the address, we and wdata are latched on acceptance. Offset bits are ignored. cpu_req while cpu_ready=0 is ignored, with no queueing.
- Hit definition: valid[idx] && tag[idx]==addr tag, evaluated in LOOKUP.
- IDLE: cpu_ready=1. Accepting a request moves to LOOKUP.
- LOOKUP: cb_index=idx.
  - Read hit: latch cb_dout, hit_cnt+1, go to RESP.
  - Read miss: miss_cnt+1, go to MEM_RD.
  - Write: record hit/miss (counter updates the same way), go to MEM_WR.
- MEM_RD: mem_req=1, mem_we=0. On mem_ack, latch mem_rdata and go to FILL.
- FILL: cb_we=1 for exactly one cycle with cb_index=idx and cb_din=fill data. Write tag[idx] and set valid[idx]. Go to RESP with rdata=fill data.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=wdata. On mem_ack, go to UPD if the lookup hit, else RESP. This is write-through, no write-allocate.
- UPD: cb_we=1 for one cycle with cb_din=wdata. Go to RESP.
- RESP: cpu_valid=1 for one cycle; cpu_rdata holds the read data (0 for writes). Go to IDLE.
- Latency from the accept edge to cpu_valid:
  - read hit: 2 cycles
  - read miss: 3 cycles plus memory wait
  - write: 2 (miss) or 3 (hit) cycles plus memory wait
- Signal stability: cb_index and cb_din stay stable whenever cb_we=1. cb_we is never asserted outside FILL and UPD. mem_* outputs stay stable while mem_req=1.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- Conflict replacement: a read miss to an index holding a different valid tag overwrites the tag and data, with no writeback (write-through memory is already current).
- rst mid-operation: mem_req drops the next cycle. No cpu_valid is issued for the aborted request. A late mem_ack is ignored.
- Counters saturate at 32'hFFFF_FFFF.

Decomposition:
- Shared define file: the cache geometry constants (_1K, _4B, ENTRY/OFFSET/TAG widths) and the state encodings (IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, UPD, RESP).
- One natural sub-module, cache_tag_array: 1K x (TAG_WIDTH+1) with combinational read, synchronous write, and synchronous clear of the valid bits.

Test Plan:
- Cold read at addr 32'h0000_0008 with mem returning 32'hDEAD_BEEF after 3 cycles:
  - required: mem_req with mem_addr=32'h8
  - required: cb_we pulse at index 2, then cpu_valid with rdata=32'hDEADBEEF
  - required: miss_cnt=1
- Repeat read of 32'h0000_0008: cpu_valid 2 cycles after accept, rdata=32'hDEADBEEF, no mem_req, hit_cnt=1.
- Write 32'h0FF0 to 32'h0000_0008 (hit):
  - required: mem write of 32'h0FF0 to 32'h8, then cb_we with din=32'h0FF0
  - required: a subsequent read returns 32'h0FF0 without mem_req.
- Write to 32'h0000_0018 (miss, index 6): memory write only, no cb_we. A following read misses and fetches.
- Conflict: read 32'h0000_1008 (index 2, new tag) -> miss and refill; a subsequent read of 32'h8 misses again.
- Assert rst during MEM_RD, then pulse mem_ack:
  - required: no cpu_valid, state IDLE
  - required: a read of 32'h8 misses (valid bits cleared).
